regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised decode-stage register file with an integrated scoreboard.
//  Provides NUM_READ registered read ports and one write-back port.
//  Tracks one busy bit per register: set when a producer is issued, cleared when it writes back.
//  Reports per-port busy status so decode can raise stall_flag on RAW hazards.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   register address width; NUM_REGS = 2**ADDR_W
//  NUM_READ  2   number of read ports (1..4)
//  ZERO_REG  1   1: register 0 reads as 0, ignores writes and issue
// PORTS
//  clk          in   1                  single clock; all state updates on posedge
//  reset        in   1                  synchronous, active-high
//  stall_flag   in   1                  1: hold read outputs; ignore issue
//  rd_addr      in   NUM_READ*ADDR_W    packed read addresses; port k = bits [k*ADDR_W +: ADDR_W]
//  rd_data      out  NUM_READ*DATA_W    packed registered read data
//  rd_busy      out  NUM_READ           registered busy flag of the register read on port k
//  hazard       out  1                  OR of rd_busy (registered)
//  issue_valid  in   1                  mark issue_addr busy (in-flight producer)
//  issue_addr   in   ADDR_W             destination register of the issued instruction
//  reg_wr       in   1                  write-back enable
//  reg_wr_addr  in   ADDR_W             write-back address
//  reg_wr_data  in   DATA_W             write-back data
// BEHAVIOUR
//  - Reset (reset=1 at posedge): all registers 0; all busy bits 0; rd_data, rd_busy, hazard 0.
//    Reset dominates every other input, including mid-operation writes and issues.
//  - Read: 1-cycle latency. If stall_flag=0 at posedge, rd_data[k] <= reg[rd_addr[k]] and
//    rd_busy[k] <= busy[rd_addr[k]]. If stall_flag=1, rd_data, rd_busy and hazard hold their values.
//  - Write: if reg_wr=1 at posedge, reg[reg_wr_addr] <= reg_wr_data and busy[reg_wr_addr] <= 0.
//    Writes are not gated by stall_flag.
//  - Issue: if issue_valid=1 and stall_flag=0 at posedge, busy[issue_addr] <= 1.
//  - Same-register write-back and issue in one cycle: set wins (busy=1); the data is still written.
//  - Several ports reading one address: all ports return identical data and busy.
//  - ZERO_REG=1: address 0 always reads 0 with busy 0; writes and issue to address 0 are dropped.
//  - Read of a register being written in the same cycle: see CONFIGURATION.
//  - Registers and busy bits are single-ported per cycle (one write, one issue); no wrap or overflow cases.
// CONFIGURATION
//  RF_BYPASS_EN defined:
//    Write-through forwarding. If reg_wr=1, reg_wr_addr==rd_addr[k] and the address is not a
//    dropped zero-register access, rd_data[k] <= reg_wr_data and rd_busy[k] <= issue-set
//    (0 unless the same address is issued in that cycle).
//  RF_BYPASS_EN undefined:
//    rd_data[k] <= the pre-write register value; rd_busy[k] <= pre-write busy (1 if in flight).
//    Decode re-reads the register after the stall.
// STRUCTURE
//  - regfile_pkg: RF_DATA_W, RF_ADDR_W and RF_NUM_READ defaults; the zero-register index constant;
//    the reg_addr_t/reg_data_t typedefs used by decode and write-back.
//  - Sub-module regfile_busy_tracker: NUM_REGS busy bits with set (issue), clear (write-back),
//    set-wins priority, zero-register masking and NUM_READ lookup ports.
//  - Top level holds the data array, the read registers, the stall hold and the optional bypass mux.
// TESTING
//  1. Assert reset, then release: all rd_data=0, rd_busy=0, hazard=0; reading r5 returns 0.
//  2. Write r4=0x4, r15=0xF; next cycle read r4/r15 -> rd_data after 1 cycle = 0x4 / 0xF, busy 0.
//  3. Issue r7, read r7 -> rd_busy=1, hazard=1; write back r7=0x77 -> next read 0x77, busy 0.
//  4. Same cycle: write r9=0x99 and issue r9 -> busy[r9]=1 and a later read returns 0x99 with busy 1.
//  5. Same-cycle write r3=0x33 and read r3: with RF_BYPASS_EN -> 0x33, busy 0;
//     without it -> old value, busy as before.
//  6. stall_flag=1 for 3 cycles while rd_addr changes -> outputs frozen and issue ignored;
//     write r0=0xFF -> r0 still reads 0. Reset asserted mid-stall -> all state 0 the next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file types and default sizes for decode and write-back.
// Build option: define RF_BYPASS_EN for write-through forwarding on reads.
package regfile_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_NUM_READ = 2;
    localparam int RF_ZERO_IDX = 0;

    typedef logic [RF_ADDR_W-1:0] reg_addr_t;
    typedef logic [RF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_busy_tracker.sv
// Per-register busy bits: set on issue, clear on write-back, set wins.
// Register 0 never goes busy when ZERO_REG is enabled.
module regfile_busy_tracker
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_READ = RF_NUM_READ,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       set_en,
    input  logic [ADDR_W-1:0]          set_addr,
    input  logic                       clr_en,
    input  logic [ADDR_W-1:0]          clr_addr,
    input  logic [NUM_READ*ADDR_W-1:0] lk_addr,
    output logic [NUM_READ-1:0]        lk_busy
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [NUM_REGS-1:0] busy_q;

    // Update every busy bit; issue takes priority over write-back
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if ((ZERO_REG != 0) && (i == RF_ZERO_IDX))
                    busy_q[i] <= 1'b0;
                else if (set_en && (set_addr == ADDR_W'(i)))
                    busy_q[i] <= 1'b1;
                else if (clr_en && (clr_addr == ADDR_W'(i)))
                    busy_q[i] <= 1'b0;
            end
        end
    end

    // Pre-update busy lookup for each read port
    always_comb begin
        lk_busy = '0;
        for (int k = 0; k < NUM_READ; k++)
            lk_busy[k] = busy_q[lk_addr[k*ADDR_W +: ADDR_W]];
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with registered reads and busy scoreboard.
// Build option: RF_BYPASS_EN forwards same-cycle write-back data to reads.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_READ = RF_NUM_READ,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall_flag,
    input  logic [NUM_READ*ADDR_W-1:0] rd_addr,
    output logic [NUM_READ*DATA_W-1:0] rd_data,
    output logic [NUM_READ-1:0]        rd_busy,
    output logic                       hazard,
    input  logic                       issue_valid,
    input  logic [ADDR_W-1:0]          issue_addr,
    input  logic                       reg_wr,
    input  logic [ADDR_W-1:0]          reg_wr_addr,
    input  logic [DATA_W-1:0]          reg_wr_data
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]          regs [NUM_REGS];
    logic [NUM_READ-1:0]        busy_now;
    logic [NUM_READ*DATA_W-1:0] rd_data_d;
    logic [NUM_READ-1:0]        rd_busy_d;
    logic                       wr_ok;

    assign wr_ok = reg_wr &&
        !((ZERO_REG != 0) && (reg_wr_addr == ADDR_W'(RF_ZERO_IDX)));

`ifdef RF_BYPASS_EN
    logic set_ok;
    assign set_ok = issue_valid && !stall_flag &&
        !((ZERO_REG != 0) && (issue_addr == ADDR_W'(RF_ZERO_IDX)));
`endif

    regfile_busy_tracker #(
        .ADDR_W   (ADDR_W),
        .NUM_READ (NUM_READ),
        .ZERO_REG (ZERO_REG)
    ) u_busy (
        .clk      (clk),
        .reset    (reset),
        .set_en   (issue_valid && !stall_flag),
        .set_addr (issue_addr),
        .clr_en   (reg_wr),
        .clr_addr (reg_wr_addr),
        .lk_addr  (rd_addr),
        .lk_busy  (busy_now)
    );

    // Data array: cleared on reset, written by write-back regardless of stall
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wr_ok) begin
            regs[reg_wr_addr] <= reg_wr_data;
        end
    end

    // Next read values, optionally forwarding the in-flight write-back
    always_comb begin
        rd_data_d = '0;
        rd_busy_d = '0;
        for (int k = 0; k < NUM_READ; k++) begin
            rd_data_d[k*DATA_W +: DATA_W] = regs[rd_addr[k*ADDR_W +: ADDR_W]];
            rd_busy_d[k] = busy_now[k];
`ifdef RF_BYPASS_EN
            if (wr_ok && (reg_wr_addr == rd_addr[k*ADDR_W +: ADDR_W])) begin
                rd_data_d[k*DATA_W +: DATA_W] = reg_wr_data;
                rd_busy_d[k] = set_ok &&
                    (issue_addr == rd_addr[k*ADDR_W +: ADDR_W]);
            end
`endif
        end
    end

    // Registered read outputs, frozen while decode is stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
            rd_busy <= '0;
            hazard  <= 1'b0;
        end else if (!stall_flag) begin
            rd_data <= rd_data_d;
            rd_busy <= rd_busy_d;
            hazard  <= |rd_busy_d;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with hand-computed expectations.
// Honours RF_BYPASS_EN for the same-cycle write/read case.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_flag;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        hazard;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic        reg_wr;
    logic [4:0]  reg_wr_addr;
    logic [31:0] reg_wr_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .stall_flag  (stall_flag),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .hazard      (hazard),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .reg_wr      (reg_wr),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic wr(input logic en, input logic [4:0] a,
                      input logic [31:0] d);
        reg_wr      = en;
        reg_wr_addr = a;
        reg_wr_data = d;
    endtask

    task automatic iss(input logic en, input logic [4:0] a);
        issue_valid = en;
        issue_addr  = a;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] d0,
                              input logic [31:0] d1, input logic [1:0] b,
                              input logic h);
        check({tag, ".d0"}, rd_data[31:0], d0);
        check({tag, ".d1"}, rd_data[63:32], d1);
        check({tag, ".busy"}, rd_busy, b);
        check({tag, ".haz"}, hazard, h);
    endtask

    initial begin
        reset = 1'b1;
        stall_flag = 1'b0;
        rd(5'd0, 5'd0);
        wr(1'b0, 5'd0, 32'h0);
        iss(1'b0, 5'd0);
        tick();
        tick();
        expect_out("reset", 32'h0, 32'h0, 2'b00, 1'b0);

        reset = 1'b0;
        rd(5'd5, 5'd5);
        tick();
        expect_out("rd_r5", 32'h0, 32'h0, 2'b00, 1'b0);

        // write r4, r15 then read both
        rd(5'd0, 5'd0);
        wr(1'b1, 5'd4, 32'h4);
        tick();
        wr(1'b1, 5'd15, 32'hF);
        tick();
        wr(1'b0, 5'd0, 32'h0);
        rd(5'd4, 5'd15);
        tick();
        expect_out("rd_r4_r15", 32'h4, 32'hF, 2'b00, 1'b0);

        // issue r7, read on both ports, then write back
        iss(1'b1, 5'd7);
        tick();
        iss(1'b0, 5'd0);
        rd(5'd7, 5'd7);
        tick();
        expect_out("r7_busy", 32'h0, 32'h0, 2'b11, 1'b1);
        rd(5'd4, 5'd4);
        wr(1'b1, 5'd7, 32'h77);
        tick();
        wr(1'b0, 5'd0, 32'h0);
        rd(5'd7, 5'd7);
        tick();
        expect_out("r7_wb", 32'h77, 32'h77, 2'b00, 1'b0);

        // write and issue r9 in the same cycle
        rd(5'd4, 5'd4);
        wr(1'b1, 5'd9, 32'h99);
        iss(1'b1, 5'd9);
        tick();
        wr(1'b0, 5'd0, 32'h0);
        iss(1'b0, 5'd0);
        rd(5'd9, 5'd4);
        tick();
        expect_out("r9_setwins", 32'h99, 32'h4, 2'b01, 1'b1);

        // r3=0x11 in flight, then write 0x33 while reading r3
        rd(5'd4, 5'd4);
        wr(1'b1, 5'd3, 32'h11);
        tick();
        wr(1'b0, 5'd0, 32'h0);
        iss(1'b1, 5'd3);
        tick();
        iss(1'b0, 5'd0);
        wr(1'b1, 5'd3, 32'h33);
        rd(5'd3, 5'd9);
        tick();
`ifdef RF_BYPASS_EN
        expect_out("r3_same", 32'h33, 32'h99, 2'b10, 1'b1);
`else
        expect_out("r3_same", 32'h11, 32'h99, 2'b11, 1'b1);
`endif
        wr(1'b0, 5'd0, 32'h0);
        rd(5'd3, 5'd3);
        tick();
        expect_out("r3_after", 32'h33, 32'h33, 2'b00, 1'b0);

        // stall: outputs frozen, issue ignored, r0 write dropped
        rd(5'd4, 5'd9);
        tick();
        expect_out("pre_stall", 32'h4, 32'h99, 2'b10, 1'b1);
        stall_flag = 1'b1;
        rd(5'd15, 5'd7);
        iss(1'b1, 5'd15);
        tick();
        expect_out("stall1", 32'h4, 32'h99, 2'b10, 1'b1);
        rd(5'd3, 5'd0);
        wr(1'b1, 5'd0, 32'hFF);
        tick();
        expect_out("stall2", 32'h4, 32'h99, 2'b10, 1'b1);
        wr(1'b0, 5'd0, 32'h0);
        rd(5'd7, 5'd15);
        tick();
        expect_out("stall3", 32'h4, 32'h99, 2'b10, 1'b1);
        stall_flag = 1'b0;
        iss(1'b1, 5'd0);
        rd(5'd15, 5'd0);
        tick();
        expect_out("unstall", 32'hF, 32'h0, 2'b00, 1'b0);
        iss(1'b0, 5'd0);
        rd(5'd0, 5'd0);
        tick();
        expect_out("r0_zero", 32'h0, 32'h0, 2'b00, 1'b0);

        // reset in the middle of a stall with write and issue pending
        rd(5'd4, 5'd9);
        tick();
        expect_out("pre_rst", 32'h4, 32'h99, 2'b10, 1'b1);
        stall_flag = 1'b1;
        wr(1'b1, 5'd4, 32'h55);
        iss(1'b1, 5'd4);
        reset = 1'b1;
        tick();
        expect_out("mid_rst", 32'h0, 32'h0, 2'b00, 1'b0);
        reset = 1'b0;
        stall_flag = 1'b0;
        wr(1'b0, 5'd0, 32'h0);
        iss(1'b0, 5'd0);
        tick();
        expect_out("post_rst", 32'h0, 32'h0, 2'b00, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
